// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : bit timing defaults and frame-state encoding for the UART link
// Revision : 1.0
// ============================================================================
package uart_pkg;

   localparam int c_CLKS_PER_BIT = 108;
   localparam int c_DATA_BITS    = 8;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_START = 2'd1;
   localparam logic [1:0] c_ST_DATA  = 2'd2;
   localparam logic [1:0] c_ST_STOP  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = c_ST_IDLE,
      ST_START = c_ST_START,
      ST_DATA  = c_ST_DATA,
      ST_STOP  = c_ST_STOP
   } frame_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// uart_baud_counter : counts 0..COUNT-1, ticks on the last count, sync clear
// Revision : 1.0
// ============================================================================
module uart_baud_counter #(
   parameter int COUNT = 108
) (
   input  logic clk_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int              c_CNT_W = $clog2(COUNT);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(COUNT - 1);

   logic [c_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         if (cnt_q == c_LAST) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign tick_o = en_i && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// uart_tx_framer : 8N1 transmit framer with a one-byte holding register
// Revision : 1.0
// ============================================================================
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
   parameter int DATA_BITS    = c_DATA_BITS
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic [7:0] Parallel_In,
   input  logic       Load,
   output logic       Ready,
   output logic       Serial_Out,
   output logic       Busy,
   output logic       Overrun
);

   localparam logic [2:0] c_LAST_IDX = 3'(DATA_BITS - 1);

   frame_state_e state_q;
   logic [7:0]   shift_q;
   logic [2:0]   idx_q;
   logic [7:0]   hold_q;
   logic         hold_valid_q;
   logic         serial_q;
   logic         busy_q;
   logic         overrun_q;

   logic         accept_d;
   logic         cnt_clr_d;
   logic         tick_d;

   assign accept_d  = Load && !hold_valid_q;
   // Holding the counter at zero while idle makes every frame start on a fresh bit period.
   assign cnt_clr_d = Reset || (state_q == ST_IDLE);

   uart_baud_counter #(
      .COUNT (CLKS_PER_BIT)
   ) u_baud (
      .clk_i  (CLOCK_50),
      .clr_i  (cnt_clr_d),
      .en_i   (1'b1),
      .tick_o (tick_d)
   );

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         idx_q        <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         serial_q     <= 1'b1;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q <= Load && hold_valid_q;
         if (accept_d) begin
            hold_q       <= Parallel_In;
            hold_valid_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               serial_q <= 1'b1;
               busy_q   <= 1'b0;
               if (hold_valid_q) begin
                  shift_q      <= hold_q;
                  hold_valid_q <= 1'b0;
                  serial_q     <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= ST_START;
               end
            end
            ST_START: begin
               if (tick_d) begin
                  serial_q <= shift_q[0];
                  idx_q    <= '0;
                  state_q  <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick_d) begin
                  if (idx_q == c_LAST_IDX) begin
                     serial_q <= 1'b1;
                     state_q  <= ST_STOP;
                  end else begin
                     shift_q  <= shift_q >> 1;
                     serial_q <= shift_q[1];
                     idx_q    <= idx_q + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (tick_d) begin
                  // A pending byte chains straight into the next start bit.
                  if (hold_valid_q) begin
                     shift_q      <= hold_q;
                     hold_valid_q <= 1'b0;
                     serial_q     <= 1'b0;
                     state_q      <= ST_START;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Ready      = !hold_valid_q;
   assign Serial_Out = serial_q;
   assign Busy       = busy_q;
   assign Overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_framer : directed frame checks for uart_tx_framer
// Revision : 1.0
// ============================================================================
module tb_uart_tx_framer;

   localparam int c_CLKS = 108;

   typedef struct {
      logic [7:0] data;
      logic [9:0] line;   // bit 0 = start bit, bit 9 = stop bit
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       load;
   logic       ready, serial, busy, overrun;

   int errors = 0;
   int checks = 0;

   uart_tx_framer #(
      .CLKS_PER_BIT (c_CLKS),
      .DATA_BITS    (8)
   ) dut (
      .CLOCK_50    (clk),
      .Reset       (rst),
      .Parallel_In (din),
      .Load        (load),
      .Ready       (ready),
      .Serial_Out  (serial),
      .Busy        (busy),
      .Overrun     (overrun)
   );

   always #10 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Entered at the negedge of the first start-bit cycle; leaves at the negedge after the stop bit.
   task automatic check_frame(input logic [9:0] exp, input string nm);
      for (int k = 0; k < 10; k++) begin
         int bad = 0;
         for (int c = 0; c < c_CLKS; c++) begin
            if (serial !== exp[k] || busy !== 1'b1) bad++;
            @(negedge clk);
         end
         chk($sformatf("%s_bit%0d_badcycles", nm, k), 32'(bad), 32'd0);
      end
   endtask

   task automatic wait_start(input string nm);
      int n = 0;
      while (serial !== 1'b0 && n < 5) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_start_seen"}, {31'd0, serial}, 32'd0);
   endtask

   task automatic load_byte(input logic [7:0] d);
      load = 1'b1;
      din  = d;
      @(negedge clk);
      load = 1'b0;
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{8'hA5, 10'b1_10100101_0, "a5"};
      vecs[1] = '{8'h55, 10'b1_01010101_0, "55"};
      vecs[2] = '{8'hAA, 10'b1_10101010_0, "aa"};
      vecs[3] = '{8'h81, 10'b1_10000001_0, "81"};
      vecs[4] = '{8'h96, 10'b1_10010110_0, "96"};

      rst = 1'b1; load = 1'b0; din = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_serial", {31'd0, serial}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single frames with exact accept/start latency
      for (int i = 0; i < 4; i++) begin
         load_byte(vecs[i].data);
         chk({vecs[i].name, "_ready_low"}, {31'd0, ready}, 32'd0);
         chk({vecs[i].name, "_still_idle"}, {30'd0, busy, serial}, 32'd1);
         @(negedge clk);
         chk({vecs[i].name, "_ready_back"}, {31'd0, ready}, 32'd1);
         chk({vecs[i].name, "_start_now"}, {30'd0, busy, serial}, 32'd2);
         check_frame(vecs[i].line, vecs[i].name);
         chk({vecs[i].name, "_idle_after"}, {30'd0, busy, serial}, 32'd1);
         repeat (5) @(negedge clk);
      end

      // Back-to-back 0x00 / 0xFF with an overrun byte that must be dropped
      load_byte(8'h00);
      wait_start("b2b");
      fork
         begin
            check_frame(10'b1_00000000_0, "b2b_00");
            check_frame(10'b1_11111111_0, "b2b_ff");
         end
         begin
            load_byte(8'hFF);
            repeat (100) @(negedge clk);
            chk("b2b_pending_ready", {31'd0, ready}, 32'd0);
            load = 1'b1;
            din  = 8'h42;
            @(negedge clk);
            chk("overrun_pulse", {31'd0, overrun}, 32'd1);
            load = 1'b0;
            din  = 8'h00;
            @(negedge clk);
            chk("overrun_clear", {31'd0, overrun}, 32'd0);
         end
      join
      begin
         int lows = 0;
         chk("b2b_busy_fall", {31'd0, busy}, 32'd0);
         repeat (300) begin
            if (serial !== 1'b1 || busy !== 1'b0) lows++;
            @(negedge clk);
         end
         chk("dropped_byte_absent", 32'(lows), 32'd0);
      end

      // Reset 300 cycles into a 0x3C frame with a byte pending
      load_byte(8'h3C);
      wait_start("rst3c");
      load_byte(8'h11);
      repeat (298) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_serial", {31'd0, serial}, 32'd1);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ready", {31'd0, ready}, 32'd1);
      rst = 1'b0;
      begin
         int bad = 0;
         repeat (2200) begin
            if (serial !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) bad++;
            @(negedge clk);
         end
         chk("midrst_quiet", 32'(bad), 32'd0);
      end

      // 0x96 with Parallel_In toggling every cycle after acceptance
      load_byte(vecs[4].data);
      wait_start("tog");
      fork
         check_frame(vecs[4].line, vecs[4].name);
         repeat (10 * c_CLKS) begin
            din = ~din;
            @(negedge clk);
         end
      join
      chk("tog_idle_after", {30'd0, busy, serial}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_framer.md
# uart_tx_framer

Transmit-side UART framer. It accepts bytes over a valid/ready handshake, holds one pending byte, and serialises each as 8N1 (start bit, 8 data bits LSB first, one stop bit) on a single idle-high line. It sits directly upstream of the link receiver and drives that receiver's serial input. Bit period matches the receiver: 108 cycles of the 50 MHz clock (2.16 µs), so the receiver's half-bit timer lands mid-bit.

## Interface
Parameters:
- CLKS_PER_BIT, 108: clock cycles per bit; legal range ≥ 4.
- DATA_BITS, 8: data bits per frame; fixed at 8 in this revision.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Parallel_In  in  8  byte to transmit; sampled only on an accepting edge.
- Load  in  1  byte valid; accepted on an edge where Load && Ready.
- Ready  out  1  holding register empty; combinational from holding-valid flag.
- Serial_Out  out  1  serial line; registered; idle high.
- Busy  out  1  high while a frame (start through stop) is on the line; registered.
- Overrun  out  1  one-cycle pulse when Load is high while Ready is low; byte dropped.

## Operation
- Reset values: Serial_Out=1, Busy=0, Overrun=0, Ready=1 (holding empty), FSM=IDLE, counters=0.
- Holding register: written on an accepting edge. Cleared when the FSM moves it to the shifter. Ready is low while it is full.
- FSM states:
  - IDLE: Serial_Out=1. If holding is full: shifter←holding, holding cleared, Serial_Out←0, go to START.
  - START: hold low for CLKS_PER_BIT cycles, then Serial_Out←shifter[0], bit index=0, go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles. On bit end with index<7: shift right, drive next bit, index+1. At index=7: Serial_Out←1, go to STOP.
  - STOP: high for CLKS_PER_BIT cycles. On the last cycle, if holding is full, reload the shifter and go to START with Serial_Out←0 (back-to-back, no idle gap). Otherwise go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and restarts at every state entry. Bit end is at count==CLKS_PER_BIT-1.
- Bit index is 3 bits. Counter width is $clog2(CLKS_PER_BIT).
- Load while Ready is low: byte ignored, Overrun pulses for 1 cycle, holding contents unchanged.
- Load on the same edge the holding register empties: not accepted (Ready was low that cycle). The byte is accepted on the next edge if Load stays high.
- Parallel_In changes after acceptance have no effect on the frame in flight.
- Reset mid-frame: the next edge forces all reset values. The line goes high immediately, the truncated frame is abandoned, and the pending byte is discarded.

## Timing
- Accept at edge E0 while in IDLE: Ready low after E0. After E1, Serial_Out=0, Busy=1, and Ready=1 again.
- Frame length is exactly 10×CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
- Busy falls on the edge where the line enters IDLE. It stays high continuously across back-to-back frames.
- Throughput: one byte per 10×CLKS_PER_BIT cycles when Load is kept supplied.
- A pending byte may be accepted at any point during a frame. Its start bit follows the stop bit with zero gap.

## Structure
- Shared package (uart_pkg): CLKS_PER_BIT default, DATA_BITS, and the frame state encoding (IDLE/START/DATA/STOP as 2-bit constants), shared with the receiver.
- One natural sub-module: uart_baud_counter (inputs: clock, sync clear, enable; output: bit-end tick). The receiver's half-bit timer can reuse it with a different count.

## Test plan
- Single byte 0xA5 after reset → line: low 108 cycles, then bits 1,0,1,0,0,1,0,1 at 108 cycles each, then high 108 cycles. Busy high for 1080 cycles. Ready low for exactly 1 cycle.
- Bytes 0x00 and 0xFF loaded back to back (second accepted mid-frame) → 2160 contiguous Busy cycles. Start bit of 0xFF immediately follows the stop bit of 0x00.
- Third Load while holding is full → Overrun pulses 1 cycle. The dropped byte never appears on the line; the first two frames are unchanged.
- Reset asserted 300 cycles into a 0x3C frame → Serial_Out=1, Busy=0, Ready=1 after the next edge. Pending byte lost, no further transitions.
- Loopback into the receiver, bytes 0x55, 0xAA, 0x81 → receiver Parallel_Out matches each byte after its Finished_Flag returns high.
- Parallel_In toggled every cycle after acceptance of 0x96 → transmitted bits are 0,1,1,0,1,0,0,1 (LSB first).
